pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline stage register for the five-stage MIPS core: a generic replacement for the hand-written per-stage latches (D/E/M/W).
- Carries a PC, a destination register address and LANES data lanes per entry.
- Uses a valid/ready handshake with a two-entry skid buffer, so upstream stalls need no combinational path from downstream ready.
- Supports a flush that can preserve the PC for exception/EPC use, and counts bubble cycles for performance monitoring.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_slot.sv | 42 ++++
 rtl/pipe_stage_reg.sv | 170 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the elastic pipeline stage register.
//   state_t  - occupancy of the two-slot stage (EMPTY / ONE / TWO)
//   PC_W     - program counter width
//   PC_RST   - program counter value after reset
//   data_w() - total lane-bus width for a given lane count and lane width
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] PC_RST = 32'h0;

    function automatic int data_w(input int lanes, input int lane_w);
        return lanes * lane_w;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one entry register of the pipeline stage (pc, wa, data, valid).
// Ports:
//   clk, rst        clock (rising edge), synchronous active-low reset
//   clear           empty the slot and zero its contents (wins over load)
//   load            capture in_pc/in_wa/in_data and mark the slot valid
//   in_pc/wa/data   entry to capture
//   pc/wa/data      stored entry
//   valid           slot holds an entry
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int WA_W   = 5,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [WA_W-1:0]   in_wa,
    input  logic [DATA_W-1:0] in_data,
    output logic [PC_W-1:0]   pc,
    output logic [WA_W-1:0]   wa,
    output logic [DATA_W-1:0] data,
    output logic              valid
);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            pc    <= PC_RST;
            wa    <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= in_pc;
            wa    <= in_wa;
            data  <= in_data;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline stage register with a two-entry skid
// buffer, flush with optional PC preservation and a bubble counter.
// Handshake: a beat moves when valid and ready are both high at a rising
// edge; a producer keeps its beat stable until it moves; ready never
// depends combinationally on valid, and in_ready is a register.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   flush               drop held entries and the incoming beat
//   in_valid/in_ready   upstream handshake
//   in_pc/in_wa/in_data incoming beat
//   out_valid/out_ready downstream handshake
//   out_pc/out_wa/out_data head entry (wa/data zeroed while empty)
//   bubble_cnt          saturating count of cycles with out_valid=0
// The FSM state is the signal 'state'.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int LANE_W  = 32,
    parameter int WA_W    = 5,
    parameter int KEEP_PC = 1,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_pc,
    input  logic [WA_W-1:0]         in_wa,
    input  logic [LANES*LANE_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [WA_W-1:0]         out_wa,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic [CNT_W-1:0]        bubble_cnt
);

    localparam int DATA_W = data_w(LANES, LANE_W);

    state_t state, state_nxt;

    logic acc, deq;
    logic head_load, head_clear, head_from_skid;
    logic skid_load, skid_clear;

    logic [PC_W-1:0]   head_pc, skid_pc, head_in_pc, last_pc;
    logic [WA_W-1:0]   head_wa, skid_wa, head_in_wa;
    logic [DATA_W-1:0] head_data, skid_data, head_in_data;
    logic              head_valid, skid_valid;

    assign acc = in_valid & in_ready;
    assign deq = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        head_clear     = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_nxt  = EMPTY;
            head_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_nxt = ONE;
                        head_load = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && !deq) begin
                        state_nxt = TWO;
                        skid_load = 1'b1;
                    end else if (acc && deq) begin
                        head_load = 1'b1;
                    end else if (deq) begin
                        state_nxt  = EMPTY;
                        head_clear = 1'b1;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a dequeue can happen.
                    if (deq) begin
                        state_nxt      = ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    state_nxt  = EMPTY;
                    head_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign head_in_pc   = head_from_skid ? skid_pc   : in_pc;
    assign head_in_wa   = head_from_skid ? skid_wa   : in_wa;
    assign head_in_data = head_from_skid ? skid_data : in_data;

    pipe_slot #(.WA_W(WA_W), .DATA_W(DATA_W)) u_head (
        .clk     (clk),
        .rst     (rst),
        .clear   (head_clear),
        .load    (head_load),
        .in_pc   (head_in_pc),
        .in_wa   (head_in_wa),
        .in_data (head_in_data),
        .pc      (head_pc),
        .wa      (head_wa),
        .data    (head_data),
        .valid   (head_valid)
    );

    pipe_slot #(.WA_W(WA_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clear   (skid_clear),
        .load    (skid_load),
        .in_pc   (in_pc),
        .in_wa   (in_wa),
        .in_data (in_data),
        .pc      (skid_pc),
        .wa      (skid_wa),
        .data    (skid_data),
        .valid   (skid_valid)
    );

    // last_pc follows every accepted beat, including one accepted in a
    // flush cycle, so the EPC logic can still see the faulting PC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= EMPTY;
            in_ready   <= 1'b1;
            last_pc    <= PC_RST;
            bubble_cnt <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != TWO);
            if (acc) begin
                last_pc <= in_pc;
            end
            if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = (state != EMPTY);

    // While empty, wa/data are zero so a bubble never writes the register
    // file; out_pc shows the preserved PC (or zero when not preserving).
    assign out_pc   = out_valid ? head_pc : ((KEEP_PC != 0) ? last_pc : PC_RST);
    assign out_wa   = out_valid ? head_wa : '0;
    assign out_data = out_valid ? head_data : '0;

    // Slot occupancy flags must agree with the FSM state.
    a_head_valid: assert property (@(posedge clk) disable iff (!rst)
        head_valid == (state != EMPTY));
    a_skid_valid: assert property (@(posedge clk) disable iff (!rst)
        skid_valid == (state == TWO));

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int WA_W   = 5;
  localparam int DW     = LANES * LANE_W;
  localparam int ENT_W  = 32 + WA_W + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   in_pc = '0;
  logic [WA_W-1:0] in_wa = '0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready, out_valid;
  logic [31:0]   out_pc;
  logic [WA_W-1:0] out_wa;
  logic [DW-1:0] out_data;
  logic [15:0]   bubble_cnt;

  logic          k0_in_ready, k0_out_valid;
  logic [31:0]   k0_out_pc;
  logic [WA_W-1:0] k0_out_wa;
  logic [DW-1:0] k0_out_data;
  logic [15:0]   k0_bubble_cnt;

  logic          c4_in_ready, c4_out_valid;
  logic [31:0]   c4_out_pc;
  logic [WA_W-1:0] c4_out_wa;
  logic [DW-1:0] c4_out_data;
  logic [3:0]    c4_bubble_cnt;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_wa(in_wa), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_wa(out_wa), .out_data(out_data),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.KEEP_PC(0)) dut_k0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(k0_in_ready),
    .in_pc(in_pc), .in_wa(in_wa), .in_data(in_data),
    .out_valid(k0_out_valid), .out_ready(out_ready),
    .out_pc(k0_out_pc), .out_wa(k0_out_wa), .out_data(k0_out_data),
    .bubble_cnt(k0_bubble_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(c4_in_ready),
    .in_pc(in_pc), .in_wa(in_wa), .in_data(in_data),
    .out_valid(c4_out_valid), .out_ready(out_ready),
    .out_pc(c4_out_pc), .out_wa(c4_out_wa), .out_data(c4_out_data),
    .bubble_cnt(c4_bubble_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  // The stage behaves as a depth-2 FIFO: ready while fewer than two
  // entries are held, valid while any entry is held.
  logic [ENT_W-1:0] exp_q[$];
  logic [31:0] m_last_pc = '0;
  int m_cnt16 = 0;
  int m_cnt4  = 0;
  bit m_acc   = 0;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Applied at each rising edge with the inputs that were driven before it.
  task automatic model_edge();
    int n;
    bit rdy, vld, deq;
    n   = exp_q.size();
    rdy = (n < 2);
    vld = (n > 0);
    m_acc = in_valid && rdy;
    deq = vld && out_ready;
    if (!rst) begin
      exp_q.delete();
      m_last_pc = '0;
      m_cnt16 = 0;
      m_cnt4  = 0;
      m_acc   = 0;
      return;
    end
    if (!vld) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (m_acc) m_last_pc = in_pc;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (deq) void'(exp_q.pop_front());
      if (m_acc) exp_q.push_back({in_pc, in_wa, in_data});
    end
  endtask

  task automatic check_all();
    int n;
    logic [ENT_W-1:0] head;
    logic [31:0] e_pc, e_pc_k0;
    n = exp_q.size();
    head = (n > 0) ? exp_q[0] : '0;
    e_pc    = (n > 0) ? head[ENT_W-1 -: 32] : m_last_pc;
    e_pc_k0 = (n > 0) ? head[ENT_W-1 -: 32] : 32'h0;
    check("in_ready",   DW'(in_ready),   DW'(n < 2));
    check("out_valid",  DW'(out_valid),  DW'(n > 0));
    check("out_pc",     DW'(out_pc),     DW'(e_pc));
    check("out_wa",     DW'(out_wa),     DW'(head[DW +: WA_W]));
    check("out_data",   out_data,        head[DW-1:0]);
    check("bubble_cnt", DW'(bubble_cnt), DW'(m_cnt16));
    check("k0_out_pc",  DW'(k0_out_pc),  DW'(e_pc_k0));
    check("c4_bubble",  DW'(c4_bubble_cnt), DW'(m_cnt4));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive_beat(input logic [31:0] pc, input logic [WA_W-1:0] wa);
    in_valid = 1'b1;
    in_pc    = pc;
    in_wa    = wa;
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Offer a beat and hold it until accepted, bounded by a cycle budget.
  task automatic send_hold(input logic [31:0] pc, input logic [WA_W-1:0] wa, input int budget);
    bit done;
    done = 0;
    drive_beat(pc, wa);
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = m_acc;
    end
    if (!done) check("accept_timeout", DW'(1'b0), DW'(1'b1));
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with an upstream beat present.
    rst = 1'b0;
    drive_beat(32'h3000, 5'd1);
    @(negedge clk);
    step();
    step();
    check("rst_bubble", DW'(bubble_cnt), DW'(0));
    check("rst_pc", DW'(out_pc), DW'(0));

    // Streaming at full throughput.
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive_beat(32'h3000 + 32'(4 * k), WA_W'(k + 1));
      step();
    end
    in_valid = 1'b0;
    step();
    step();

    // Backpressure: A and B accepted, C waits until downstream drains.
    out_ready = 1'b0;
    send_hold(32'h3100, 5'd3, 4);
    send_hold(32'h3104, 5'd4, 4);
    drive_beat(32'h3108, 5'd5);
    step();
    step();
    step();
    out_ready = 1'b1;
    send_hold(32'h3108, 5'd5, 4);
    step();
    step();
    step();

    // Flush in ONE with a beat accepted in the flush cycle.
    out_ready = 1'b0;
    send_hold(32'h3200, 5'd6, 4);
    drive_beat(32'h3204, 5'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_one_pc", DW'(out_pc), DW'(32'h3204));
    step();

    // Flush in TWO: in_ready is low, so the offered beat is not accepted and
    // the preserved PC is the last accepted one.
    send_hold(32'h3010, 5'd8, 4);
    send_hold(32'h3014, 5'd9, 4);
    drive_beat(32'h3018, 5'd10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_two_pc", DW'(out_pc), DW'(32'h3014));
    step();

    // Flush and reset at the same edge.
    send_hold(32'h3300, 5'd11, 4);
    flush = 1'b1;
    rst = 1'b0;
    step();
    flush = 1'b0;
    rst = 1'b1;
    check("flush_rst_bubble", DW'(bubble_cnt), DW'(0));

    // Idle long enough to saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) step();
    check("sat_c4", DW'(c4_bubble_cnt), DW'(15));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) != 0);
      in_pc     = $urandom();
      in_wa     = WA_W'($urandom());
      in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
